// File: rtl/serial_frame_rx_if.sv
// serial_frame_rx_if: byte-stream input and word/frame output signals of the
// serial frame receiver. The master side is the UART receiver feeding bytes
// and the word consumer; the slave side is the frame receiver itself.
interface serial_frame_rx_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_err;
    logic        busy;
    logic [1:0]  mode;
    logic        word_valid;
    logic [31:0] word_data;
    logic [3:0]  word_idx;
    logic        word_is_freq;
    logic        frame_done;
    logic        frame_err;

    modport master (
        output rx_valid, rx_data, rx_err,
        input  busy, mode, word_valid, word_data, word_idx, word_is_freq,
               frame_done, frame_err
    );

    modport slave (
        input  rx_valid, rx_data, rx_err,
        output busy, mode, word_valid, word_data, word_idx, word_is_freq,
               frame_done, frame_err
    );
endinterface

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: reassembles 32-bit words from a framed UART byte stream.
// Frame: 0xFF magic, mode byte {6'b0, mode}, 2 freq words if mode[1], then
// 10 time words if mode[0]; each word is 4 bytes, LSB first. All strobes are
// registered and appear one cycle after the byte that triggers them.
// Build option: define SERIAL_RX_TIMEOUT_EN to abort a frame after
// TIMEOUT_CYCLES consecutive clocks without a byte.
module serial_frame_rx #(
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_frame_rx_if.slave bus
);
    typedef enum logic [1:0] {HUNT, MODE, FREQ, TIME} state_t;

    localparam logic [7:0] MAGIC      = 8'hFF;
    localparam logic [3:0] FREQ_WORDS = 4'd2;
    localparam logic [3:0] TIME_WORDS = 4'd10;

    state_t      state_q, state_d;
    logic [1:0]  byte_cnt_q;
    logic [3:0]  word_cnt_q;
    logic [23:0] asm_q;
    logic [1:0]  mode_q;

    logic timeout;
    logic data_ok, in_word, mode_bad, mode_empty;
    logic word_end, last_word, done_fire, err_fire;

    assign bus.busy = (state_q != HUNT);
    assign bus.mode = mode_q;

`ifdef SERIAL_RX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_q;

    // The idle count reaching TIMEOUT_CYCLES-1 means this is the last allowed idle clock.
    assign timeout = bus.busy && !bus.rx_valid &&
                     (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

    // Count idle clocks inside a frame; any byte or leaving the frame clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else if (!bus.busy || bus.rx_valid || timeout) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end
`else
    // No timeout in this build; the parameter is still referenced so both
    // builds expose the same parameter list without an unused-parameter hole.
    assign timeout = (TIMEOUT_CYCLES == 0) & 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
        end else begin
            // NOTE: sequential state always uses non-blocking assignments so
            // every register samples the pre-edge values of its neighbours.
            state_q <= state_d;
        end
    end

    // Decode strobe conditions from the current state and the incoming byte.
    always_comb begin
        data_ok    = bus.rx_valid && !bus.rx_err && (state_q != HUNT);
        in_word    = (state_q == FREQ) || (state_q == TIME);
        mode_bad   = (state_q == MODE) && (bus.rx_data[7:2] != 6'd0);
        mode_empty = (state_q == MODE) && (bus.rx_data == 8'h00);
        word_end   = data_ok && in_word && (byte_cnt_q == 2'd3);
        last_word  = word_end && (word_cnt_q == 4'd1) &&
                     ((state_q == TIME) || !mode_q[0]);
        done_fire  = (data_ok && mode_empty) || last_word;
        err_fire   = (bus.rx_valid && bus.rx_err && (state_q != HUNT)) ||
                     (data_ok && mode_bad) || timeout;
    end

    // Next-state logic: only a valid byte (or a timeout) moves the FSM.
    always_comb begin
        // NOTE: state_d gets a default before any branch so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        if (timeout) begin
            state_d = HUNT;
        end else if (bus.rx_valid) begin
            case (state_q)
                HUNT: if (bus.rx_data == MAGIC) state_d = MODE;
                MODE: begin
                    if (bus.rx_err || mode_bad) state_d = HUNT;
                    else if (bus.rx_data[1])    state_d = FREQ;
                    else if (bus.rx_data[0])    state_d = TIME;
                    else                        state_d = HUNT;
                end
                FREQ: begin
                    if (bus.rx_err)                             state_d = HUNT;
                    else if (word_end && word_cnt_q == 4'd1)    state_d = mode_q[0] ? TIME : HUNT;
                end
                TIME: begin
                    if (bus.rx_err || last_word) state_d = HUNT;
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Byte/word counters, assembly buffer and latched mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q <= 2'd0;
            word_cnt_q <= 4'd0;
            asm_q      <= 24'd0;
            mode_q     <= 2'd0;
        end else if (data_ok && (state_q == MODE) && !mode_bad) begin
            mode_q     <= bus.rx_data[1:0];
            byte_cnt_q <= 2'd0;
            word_cnt_q <= bus.rx_data[1] ? FREQ_WORDS : TIME_WORDS;
        end else if (data_ok && in_word) begin
            if (word_end) begin
                byte_cnt_q <= 2'd0;
                word_cnt_q <= ((state_q == FREQ) && (word_cnt_q == 4'd1)) ?
                              TIME_WORDS : word_cnt_q - 4'd1;
            end else begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
                case (byte_cnt_q)
                    2'd0:    asm_q[7:0]   <= bus.rx_data;
                    2'd1:    asm_q[15:8]  <= bus.rx_data;
                    2'd2:    asm_q[23:16] <= bus.rx_data;
                    default: ;
                endcase
            end
        end
    end

    // Registered outputs: strobes every cycle, word fields only on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.word_valid   <= 1'b0;
            bus.frame_done   <= 1'b0;
            bus.frame_err    <= 1'b0;
            bus.word_data    <= 32'd0;
            bus.word_idx     <= 4'd0;
            bus.word_is_freq <= 1'b0;
        end else begin
            bus.word_valid <= word_end;
            bus.frame_done <= done_fire;
            bus.frame_err  <= err_fire;
            if (word_end) begin
                bus.word_data    <= {bus.rx_data, asm_q};
                bus.word_idx     <= word_cnt_q;
                bus.word_is_freq <= (state_q == FREQ);
            end
        end
    end
endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx: directed bench for serial_frame_rx. Bytes are driven
// 1 ns after a rising edge and outputs are checked 1 ns after the edge that
// consumes the byte, i.e. exactly one cycle of latency.
module tb_serial_frame_rx;
    localparam int unsigned TMO = 50;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests  = 0;
    int   failed = 0;
    int   wv_cnt = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;

    always #5 clk = ~clk;

    serial_frame_rx_if bus_if ();

    serial_frame_rx #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    // Strobe monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus_if.word_valid) wv_cnt++;
        if (bus_if.frame_done) done_cnt++;
        if (bus_if.frame_err)  err_cnt++;
        if (bus_if.frame_done && bus_if.frame_err) both_cnt++;
    end

    // Watchdog so the run always ends.
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at 2 ms, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b, input logic e);
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = b;
        bus_if.rx_err   = e;
        @(posedge clk); #1;
        bus_if.rx_valid = 1'b0;
        bus_if.rx_err   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, input logic [3:0] idx,
                             input logic freq, input logic last);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b0);
        tests++;
        if ({bus_if.word_valid, bus_if.word_data, bus_if.word_idx, bus_if.word_is_freq,
             bus_if.frame_done, bus_if.frame_err} !== {1'b1, w, idx, freq, last, 1'b0}) begin
            failed++;
            $display("FAIL word idx%0d: got wv=%b data=%h idx=%0d freq=%b done=%b err=%b, want wv=1 data=%h idx=%0d freq=%b done=%b err=0",
                     idx, bus_if.word_valid, bus_if.word_data, bus_if.word_idx, bus_if.word_is_freq,
                     bus_if.frame_done, bus_if.frame_err, w, idx, freq, last);
        end
    endtask

    task automatic test_reset;
        bus_if.rx_valid = 1'b0;
        bus_if.rx_data  = 8'h00;
        bus_if.rx_err   = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({bus_if.busy, bus_if.mode, bus_if.word_valid, bus_if.word_data, bus_if.word_idx,
             bus_if.word_is_freq, bus_if.frame_done, bus_if.frame_err} !== 43'd0) begin
            failed++;
            $display("FAIL reset_outputs: got busy=%b mode=%0d wv=%b data=%h idx=%0d, want all zero",
                     bus_if.busy, bus_if.mode, bus_if.word_valid, bus_if.word_data, bus_if.word_idx);
        end
        rst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_full_frame;
        int wv0, d0, e0;
        wv0 = wv_cnt; d0 = done_cnt; e0 = err_cnt;
        send_byte(8'hFF, 1'b0);
        tests++;
        if (bus_if.busy !== 1'b1) begin
            failed++; $display("FAIL full_busy_after_magic: got %b, want 1", bus_if.busy);
        end
        send_byte(8'h03, 1'b0);
        tests++;
        if (bus_if.mode !== 2'd3) begin
            failed++; $display("FAIL full_mode: got %0d, want 3", bus_if.mode);
        end
        send_word(32'h11223344, 4'd2, 1'b1, 1'b0);
        send_word(32'h55667788, 4'd1, 1'b1, 1'b0);
        for (int k = 1; k <= 10; k++) send_word(32'(k), 4'(11 - k), 1'b0, k == 10);
        idle(1);
        tests++;
        if ({bus_if.word_valid, bus_if.word_data, bus_if.word_idx, bus_if.busy, bus_if.frame_done}
            !== {1'b0, 32'd10, 4'd1, 1'b0, 1'b0}) begin
            failed++;
            $display("FAIL full_hold: got wv=%b data=%h idx=%0d busy=%b done=%b, want 0/0000000a/1/0/0",
                     bus_if.word_valid, bus_if.word_data, bus_if.word_idx, bus_if.busy, bus_if.frame_done);
        end
        tests++;
        if ({wv_cnt - wv0, done_cnt - d0, err_cnt - e0} !== {32'd12, 32'd1, 32'd0}) begin
            failed++;
            $display("FAIL full_counts: got wv=%0d done=%0d err=%0d, want 12/1/0",
                     wv_cnt - wv0, done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_mode_zero;
        int wv0;
        wv0 = wv_cnt;
        send_byte(8'hFF, 1'b0);
        send_byte(8'h00, 1'b0);
        tests++;
        if ({bus_if.frame_done, bus_if.frame_err, bus_if.mode, bus_if.busy} !== {1'b1, 1'b0, 2'd0, 1'b0}) begin
            failed++;
            $display("FAIL mode_zero: got done=%b err=%b mode=%0d busy=%b, want 1/0/0/0",
                     bus_if.frame_done, bus_if.frame_err, bus_if.mode, bus_if.busy);
        end
        idle(1);
        tests++;
        if (wv_cnt - wv0 !== 0 || bus_if.frame_done !== 1'b0) begin
            failed++;
            $display("FAIL mode_zero_quiet: got wv=%0d done=%b, want 0/0", wv_cnt - wv0, bus_if.frame_done);
        end
    endtask

    task automatic test_junk_and_ff_data;
        int wv0, d0;
        wv0 = wv_cnt; d0 = done_cnt;
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        tests++;
        if ({bus_if.busy, bus_if.word_valid, bus_if.frame_done, bus_if.frame_err} !== 4'b0000) begin
            failed++;
            $display("FAIL junk_ignored: got busy=%b wv=%b done=%b err=%b, want 0000",
                     bus_if.busy, bus_if.word_valid, bus_if.frame_done, bus_if.frame_err);
        end
        send_byte(8'hFF, 1'b0);
        send_byte(8'h02, 1'b0);
        send_word(32'hFFFFFFFF, 4'd2, 1'b1, 1'b0);
        send_word(32'hFFFFFFFF, 4'd1, 1'b1, 1'b1);
        tests++;
        if ({bus_if.busy, bus_if.mode} !== {1'b0, 2'd2}) begin
            failed++; $display("FAIL ff_data_end: got busy=%b mode=%0d, want 0/2", bus_if.busy, bus_if.mode);
        end
        idle(1);
        tests++;
        if ({wv_cnt - wv0, done_cnt - d0} !== {32'd2, 32'd1}) begin
            failed++; $display("FAIL ff_data_counts: got wv=%0d done=%0d, want 2/1", wv_cnt - wv0, done_cnt - d0);
        end
    endtask

    task automatic test_bad_mode;
        send_byte(8'hFF, 1'b0);
        send_byte(8'h05, 1'b0);
        tests++;
        if ({bus_if.frame_err, bus_if.frame_done, bus_if.busy} !== 3'b100) begin
            failed++;
            $display("FAIL bad_mode: got err=%b done=%b busy=%b, want 1/0/0",
                     bus_if.frame_err, bus_if.frame_done, bus_if.busy);
        end
        send_byte(8'hFF, 1'b0);
        send_byte(8'h01, 1'b0);
        tests++;
        if ({bus_if.frame_err, bus_if.busy, bus_if.mode} !== {1'b0, 1'b1, 2'd1}) begin
            failed++;
            $display("FAIL bad_mode_recover: got err=%b busy=%b mode=%0d, want 0/1/1",
                     bus_if.frame_err, bus_if.busy, bus_if.mode);
        end
        for (int k = 1; k <= 10; k++) send_word(32'hA000_0000 + 32'(k), 4'(11 - k), 1'b0, k == 10);
    endtask

    task automatic test_rx_err;
        int wv0, e0;
        send_byte(8'h55, 1'b1);
        tests++;
        if ({bus_if.frame_err, bus_if.busy} !== 2'b00) begin
            failed++; $display("FAIL err_in_hunt: got err=%b busy=%b, want 0/0", bus_if.frame_err, bus_if.busy);
        end
        wv0 = wv_cnt; e0 = err_cnt;
        send_byte(8'hFF, 1'b0);
        send_byte(8'h01, 1'b0);
        send_word(32'h04030201, 4'd10, 1'b0, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h06, 1'b0);
        send_byte(8'h07, 1'b1);
        tests++;
        if ({bus_if.frame_err, bus_if.word_valid, bus_if.frame_done, bus_if.busy} !== 4'b1000) begin
            failed++;
            $display("FAIL rx_err_abort: got err=%b wv=%b done=%b busy=%b, want 1/0/0/0",
                     bus_if.frame_err, bus_if.word_valid, bus_if.frame_done, bus_if.busy);
        end
        idle(1);
        tests++;
        if ({wv_cnt - wv0, err_cnt - e0} !== {32'd1, 32'd1}) begin
            failed++; $display("FAIL rx_err_counts: got wv=%0d err=%0d, want 1/1", wv_cnt - wv0, err_cnt - e0);
        end
    endtask

    task automatic test_reset_mid_frame;
        int wv0, d0, e0;
        send_byte(8'hFF, 1'b0);
        send_byte(8'h03, 1'b0);
        for (int i = 0; i < 5; i++) send_byte(8'h80 + 8'(i), 1'b0);
        wv0 = wv_cnt; d0 = done_cnt; e0 = err_cnt;
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({bus_if.busy, bus_if.mode, bus_if.word_valid, bus_if.word_data, bus_if.word_idx,
             bus_if.word_is_freq, bus_if.frame_done, bus_if.frame_err} !== 43'd0) begin
            failed++;
            $display("FAIL mid_reset_outputs: got busy=%b mode=%0d data=%h idx=%0d freq=%b, want all zero",
                     bus_if.busy, bus_if.mode, bus_if.word_data, bus_if.word_idx, bus_if.word_is_freq);
        end
        idle(2);
        rst_n = 1'b1;
        send_byte(8'h00, 1'b0);
        tests++;
        if ({bus_if.busy, bus_if.frame_done, bus_if.frame_err} !== 3'b000) begin
            failed++;
            $display("FAIL mid_reset_hunt: got busy=%b done=%b err=%b, want 0/0/0",
                     bus_if.busy, bus_if.frame_done, bus_if.frame_err);
        end
        idle(1);
        tests++;
        if ({wv_cnt - wv0, done_cnt - d0, err_cnt - e0} !== 96'd0) begin
            failed++;
            $display("FAIL mid_reset_strobes: got wv=%0d done=%0d err=%0d, want 0/0/0",
                     wv_cnt - wv0, done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_timeout;
        int e0;
        e0 = err_cnt;
        send_byte(8'hFF, 1'b0);
        send_byte(8'h02, 1'b0);
`ifdef SERIAL_RX_TIMEOUT_EN
        idle(TMO - 1);
        tests++;
        if ({bus_if.frame_err, bus_if.busy} !== 2'b01) begin
            failed++; $display("FAIL timeout_early: got err=%b busy=%b, want 0/1", bus_if.frame_err, bus_if.busy);
        end
        idle(1);
        tests++;
        if ({bus_if.frame_err, bus_if.busy} !== 2'b10) begin
            failed++; $display("FAIL timeout_fire: got err=%b busy=%b, want 1/0", bus_if.frame_err, bus_if.busy);
        end
`else
        idle(TMO + 10);
        tests++;
        if ({bus_if.busy, 32'(err_cnt - e0)} !== {1'b1, 32'd0}) begin
            failed++; $display("FAIL no_timeout: got busy=%b err=%0d, want 1/0", bus_if.busy, err_cnt - e0);
        end
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(1);
`endif
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_mode_zero();
        test_junk_and_ff_data();
        test_bad_mode();
        test_rx_err();
        test_reset_mid_frame();
        test_timeout();
        idle(2);
        tests++;
        if (both_cnt !== 0) begin
            failed++; $display("FAIL done_err_overlap: got %0d cycles, want 0", both_cnt);
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
